pipelined_csel_adder: RTL and testbench

//  Parametrised, pipelined carry-select adder/subtractor. Successor to the 4-bit PG/carry-logic adder.

---
 rtl/pipelined_csel_adder_pkg.sv | 22 ++
 rtl/pipelined_csel_adder_segment.sv | 53 +++++
 rtl/pipelined_csel_adder.sv | 149 ++++++++++++++
 tb/tb_pipelined_csel_adder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_csel_adder_pkg.sv
// rtl/pipelined_csel_adder_pkg.sv - shared defaults, op encoding and geometry helpers for the carry-select adder
package pipelined_csel_adder_pkg;

   localparam int DEF_WIDTH  = 16;
   localparam int DEF_STAGES = 4;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   // Bits resolved per pipeline stage.
   function automatic int seg_width(input int width, input int stages);
      return width / stages;
   endfunction

   // Geometry is legal when the width splits evenly into 1..width stages.
   function automatic bit geometry_ok(input int width, input int stages);
      return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
   endfunction

endpackage

// File: rtl/pipelined_csel_adder_segment.sv
// rtl/pipelined_csel_adder_segment.sv - combinational carry-select segment (dual ripple, late carry mux)
module csel_segment #(
   parameter int SEG = 4
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           cin,
   output logic [SEG-1:0] s,
   output logic           co,
   output logic           c_msb_in
);

   logic [SEG-1:0] p;
   logic [SEG-1:0] g;
   logic [SEG-1:0] s0;
   logic [SEG-1:0] s1;
   logic           co0;
   logic           co1;
   logic           cm0;
   logic           cm1;

   assign p = a ^ b;
   assign g = a & b;

   // Two speculative ripple chains, one assuming carry-in 0 and one assuming 1.
   always_comb begin
      logic r0;
      logic r1;
      r0  = 1'b0;
      r1  = 1'b1;
      s0  = '0;
      s1  = '0;
      cm0 = 1'b0;
      cm1 = 1'b0;
      for (int i = 0; i < SEG; i++) begin
         s0[i] = p[i] ^ r0;
         s1[i] = p[i] ^ r1;
         // Left holding the carry into the top bit once the loop finishes.
         cm0   = r0;
         cm1   = r1;
         r0    = g[i] | (p[i] & r0);
         r1    = g[i] | (p[i] & r1);
      end
      co0 = r0;
      co1 = r1;
   end

   // The real carry-in arrives late and only steers the final mux.
   assign s        = cin ? s1  : s0;
   assign co       = cin ? co1 : co0;
   assign c_msb_in = cin ? cm1 : cm0;

endmodule

// File: rtl/pipelined_csel_adder.sv
// rtl/pipelined_csel_adder.sv - pipelined carry-select adder/subtractor with valid/ready handshake
module pipelined_csel_adder
   import pipelined_csel_adder_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STAGES = DEF_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int SEG = seg_width(WIDTH, STAGES);

   if (!geometry_ok(WIDTH, STAGES)) begin : g_bad_geometry
      $error("pipelined_csel_adder: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
   end

   logic                          adv;
   logic                          accept;
   op_e                           op;
   logic [WIDTH-1:0]              b_eff;
   logic                          c0;
   logic [STAGES-1:0]             vld;
   logic [STAGES-1:0]             cy;
   logic [STAGES-1:0][WIDTH-1:0]  acc;
   logic                          ovf_q;

   // One global advance: the whole pipe moves or the whole pipe holds.
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;
   assign accept   = in_valid && adv;

   // Subtraction is a + ~b + 1; cin only matters when adding.
   assign op    = op_e'(sub);
   assign b_eff = (op == OP_SUB) ? ~b : b;
   assign c0    = (op == OP_SUB) ? 1'b1 : cin;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int LO = k * SEG;
      localparam int BW = WIDTH - LO;

      logic             src_v;
      logic             src_c;
      logic [WIDTH-1:0] src_a;
      logic [BW-1:0]    src_b;
      logic [WIDTH-1:0] nxt_a;
      logic [SEG-1:0]   seg_s;
      logic             seg_co;
      logic             vld_q;
      logic             cy_q;
      logic [WIDTH-1:0] acc_q;

      // acc_q of stage k holds resolved segments 0..k and raw operand-a segments above.
      if (k == 0) begin : g_src
         assign src_v = accept;
         assign src_a = a;
         assign src_b = b_eff;
         assign src_c = c0;
      end else begin : g_src
         assign src_v = vld[k-1];
         assign src_a = acc[k-1];
         assign src_b = g_stage[k-1].g_bhold.b_hi;
         assign src_c = cy[k-1];
      end

      // Splice this stage's resolved segment into the travelling word.
      always_comb begin
         nxt_a            = src_a;
         nxt_a[LO +: SEG] = seg_s;
      end

      // Stage register: valid bit, partial sum and the carry into the next segment.
      always_ff @(posedge clk) begin
         if (rst) begin
            vld_q <= 1'b0;
            cy_q  <= 1'b0;
            acc_q <= '0;
         end else if (adv) begin
            vld_q <= src_v;
            cy_q  <= seg_co;
            acc_q <= nxt_a;
         end
      end

      assign vld[k] = vld_q;
      assign cy[k]  = cy_q;
      assign acc[k] = acc_q;

      if (k < STAGES - 1) begin : g_bhold
         // Only the b segments not yet consumed travel onward.
         logic [BW-SEG-1:0] b_hi;

         csel_segment #(.SEG(SEG)) u_seg (
            .a        (src_a[LO +: SEG]),
            .b        (src_b[SEG-1:0]),
            .cin      (src_c),
            .s        (seg_s),
            .co       (seg_co),
            .c_msb_in ()
         );

         // Skewed b register, shifted with the rest of the stage.
         always_ff @(posedge clk) begin
            if (rst) begin
               b_hi <= '0;
            end else if (adv) begin
               b_hi <= src_b[BW-1:SEG];
            end
         end
      end else begin : g_last
         logic seg_cm;

         csel_segment #(.SEG(SEG)) u_seg (
            .a        (src_a[LO +: SEG]),
            .b        (src_b[SEG-1:0]),
            .cin      (src_c),
            .s        (seg_s),
            .co       (seg_co),
            .c_msb_in (seg_cm)
         );

         // Signed overflow is captured alongside the final segment so it leaves from a register.
         always_ff @(posedge clk) begin
            if (rst) begin
               ovf_q <= 1'b0;
            end else if (adv) begin
               ovf_q <= seg_cm ^ seg_co;
            end
         end
      end
   end

   assign out_valid = vld[STAGES-1];
   assign sum       = acc[STAGES-1];
   assign cout      = cy[STAGES-1];
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// tb/tb_pipelined_csel_adder.sv - scoreboard bench for pipelined_csel_adder (WIDTH=16, STAGES=4)
module tb_pipelined_csel_adder;

   localparam int W = 16;
   localparam int S = 4;

   typedef logic [W+1:0] res_t;   // {cout, ovf, sum}

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   res_t exp_q[$];
   int   pop_cyc[$];
   bit   held     = 1'b0;
   res_t held_val;
   bit   rnd_ready_on = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   pipelined_csel_adder #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference from plain integer arithmetic: unsigned for sum/cout, signed range for ovf.
   function automatic res_t ref_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic cv, input logic sv);
      longint sa, sb, sr, ua, ub, ur;
      logic   co, ov;
      sa = longint'($signed(av));
      sb = longint'($signed(bv));
      ua = longint'(av);
      ub = longint'(bv);
      if (sv) begin
         sr = sa - sb;
         ur = ua - ub;
         co = (ua >= ub);
      end else begin
         sr = sa + sb + longint'(cv);
         ur = ua + ub + longint'(cv);
         co = (ur >= (longint'(1) << W));
      end
      ov = (sr > ((longint'(1) << (W-1)) - 1)) || (sr < -(longint'(1) << (W-1)));
      return {co, ov, ur[W-1:0]};
   endfunction

   // Compare process: handshake rule, hold stability, in-order results, model push on accept.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         held = 1'b0;
      end else begin
         chk("in_ready_rule", in_ready, !out_valid || out_ready);
         if (held) begin
            chk("hold_out_valid", out_valid, 1'b1);
            chk("hold_result", {cout, ovf, sum}, held_val);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL result_without_op: got 0x%0h expected no result", {cout, ovf, sum});
            end else begin
               chk("result", {cout, ovf, sum}, exp_q.pop_front());
            end
            pop_cyc.push_back(cyc);
         end
         held     = out_valid && !out_ready;
         held_val = {cout, ovf, sum};
         if (in_valid && in_ready) exp_q.push_back(ref_op(a, b, cin, sub));
      end
   end

   // Random back-pressure while enabled.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rnd_ready_on) out_ready = ($urandom % 4) != 0;
      end
   end

   // Called and returns at posedge+1; leaves in_valid low once the op is taken.
   task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv, input logic sv);
      bit done;
      done = 1'b0;
      a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         done = in_ready;
         @(posedge clk);
         #1;
      end
      chk("send_accepted", done, 1'b1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && (exp_q.size() != 0); i++) begin
         @(posedge clk);
         #1;
      end
      chk("drain_empty", exp_q.size(), 0);
   endtask

   // Empty pipe, out_ready=1: result must appear exactly S cycles after the accept cycle.
   task automatic lat_test(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic cv, input logic sv, input res_t lit);
      send(av, bv, cv, sv);
      repeat (S-2) @(posedge clk);
      @(negedge clk);
      chk({name, "_early"}, out_valid, 1'b0);
      @(posedge clk);
      @(negedge clk);
      chk({name, "_valid"}, out_valid, 1'b1);
      chk({name, "_value"}, {cout, ovf, sum}, lit);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_out_valid", out_valid, 1'b0);
      chk("reset_result", {cout, ovf, sum}, '0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("reset_in_ready", in_ready, 1'b1);

      chk("model_wrap", ref_op(16'hFFFF, 16'h0001, 1'b0, 1'b0), {1'b1, 1'b0, 16'h0000});
      chk("model_sub_neg", ref_op(16'h0005, 16'h0007, 1'b0, 1'b1), {1'b0, 1'b0, 16'hFFFE});
      chk("model_add_ovf", ref_op(16'h7FFF, 16'h0001, 1'b0, 1'b0), {1'b0, 1'b1, 16'h8000});
      chk("model_sub_ovf", ref_op(16'h8000, 16'h0001, 1'b0, 1'b1), {1'b1, 1'b1, 16'h7FFF});
      chk("model_a_minus_a", ref_op(16'h1234, 16'h1234, 1'b1, 1'b1), {1'b1, 1'b0, 16'h0000});
      @(posedge clk);
      #1;

      lat_test("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h0000});
      lat_test("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE});
      lat_test("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h8000});
      lat_test("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});
      lat_test("a_minus_a", 16'h1234, 16'h1234, 1'b1, 1'b1, {1'b1, 1'b0, 16'h0000});
      lat_test("add_cin", 16'h00FF, 16'h0F00, 1'b1, 1'b0, {1'b0, 1'b0, 16'h1000});

      // Five back-to-back ops: five results on consecutive cycles.
      pop_cyc.delete();
      for (int i = 0; i < 5; i++) send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      drain();
      chk("b2b_count", pop_cyc.size(), 5);
      if (pop_cyc.size() == 5) chk("b2b_span", pop_cyc[4] - pop_cyc[0], 4);

      // Full pipe held for three cycles, then a fifth op waits for release.
      pop_cyc.delete();
      out_ready = 1'b0;
      for (int i = 0; i < S; i++) send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      a = 16'hABCD; b = 16'h1111; cin = 1'b0; sub = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_in_ready", in_ready, 1'b0);
         chk("stall_out_valid", out_valid, 1'b1);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      send(16'hABCD, 16'h1111, 1'b0, 1'b1);
      drain();
      chk("stall_no_loss_no_dup", pop_cyc.size(), S + 1);

      // Reset with three ops in flight: none of them may emerge.
      for (int i = 0; i < 3; i++) send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", out_valid, 1'b0);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("flush_stays_empty", out_valid, 1'b0);
      end
      @(posedge clk);
      #1;
      lat_test("after_flush", 16'h4000, 16'h4000, 1'b0, 1'b0, {1'b0, 1'b1, 16'h8000});

      // Random traffic against the scoreboard.
      rnd_ready_on = 1'b1;
      for (int n = 0; n < 10000; n++) begin
         if (($urandom % 4) == 0) begin
            @(posedge clk);
            #1;
         end
         ra = (($urandom % 8) == 0) ? 16'hFFFF : W'($urandom);
         rb = (($urandom % 8) == 0) ? ra : W'($urandom);
         send(ra, rb, 1'($urandom), 1'($urandom));
      end
      rnd_ready_on = 1'b0;
      out_ready = 1'b1;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
